// File: rtl/sseg_scan_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_monitor_if
//  Purpose  : Bundles the multiplexed seven-segment display bus together
//             with the monitor's reconstructed digit words and status flags.
//  Signals  : AN[7:0]    anode enables, active-low, bit k = digit k
//             sseg[6:0]  segments a..g, active-low (sseg[0]=a)
//             DP         decimal point, active-low
//             clr_err    one-cycle pulse clearing the sticky flags
//             O0..O7     rebuilt digit words {en, hex[3:0], dp}
//             frame_done one-cycle pulse at the end of each window
//             seg_err    sticky non-hex segment pattern flag
//             anode_err  sticky multiple-anode flag
//  Modports : master = display side / bench, slave = monitor
//  Revision : 1.0  initial release
// ============================================================================
interface sseg_scan_monitor_if;
  logic [7:0] AN;
  logic [6:0] sseg;
  logic       DP;
  logic       clr_err;
  logic [5:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic       frame_done;
  logic       seg_err;
  logic       anode_err;

  modport master (
    output AN, sseg, DP, clr_err,
    input  O0, O1, O2, O3, O4, O5, O6, O7, frame_done, seg_err, anode_err
  );

  modport slave (
    input  AN, sseg, DP, clr_err,
    output O0, O1, O2, O3, O4, O5, O6, O7, frame_done, seg_err, anode_err
  );
endinterface
`default_nettype wire

// File: rtl/sseg_scan_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_monitor
//  Purpose  : Watches an eight-digit multiplexed seven-segment bus and
//             rebuilds the eight {en, hex, dp} digit words that drove it.
//             A display slot is accepted only after it has been stable for
//             STABLE_CYCLES consecutive equal samples; digits not refreshed
//             within a FRAME_CYCLES window are reported as disabled.
//  Ports    : clk    system clock, rising edge
//             reset  asynchronous active-high reset
//             bus    sseg_scan_monitor_if.slave (display bus in, words out)
//  Revision : 1.0  initial release
// ============================================================================
module sseg_scan_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_CYCLES  = 833_328
) (
  input logic               clk,
  input logic               reset,
  sseg_scan_monitor_if.slave bus
);

  localparam int c_CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int c_FRM_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  // {AN, sseg, DP} with every line inactive
  localparam logic [15:0] c_IDLE = 16'hFFFF;

  logic [15:0]        r_s1;
  logic [15:0]        r_s_prev;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_FRM_W-1:0] r_frm;
  logic [5:0]         r_dig [8];
  logic [7:0]         r_seen;
  logic               r_frame_done;
  logic               r_seg_err;
  logic               r_anode_err;

  logic       w_equal;
  logic       w_accept;
  logic       w_tc;
  logic [7:0] w_an;
  logic       w_one_low;
  logic       w_none_low;
  logic [2:0] w_idx;
  logic [3:0] w_hex;
  logic       w_hex_ok;
  logic       w_write;
  logic [7:0] w_wmask;
  logic [7:0] w_seen_eff;
  logic [5:0] w_word;

  assign w_equal  = (r_s1 == r_s_prev);
  // The counter saturates above STABLE_CYCLES-1, so this fires once per run.
  assign w_accept = w_equal && (r_cnt == c_CNT_W'(STABLE_CYCLES - 1));
  assign w_tc     = (r_frm == c_FRM_W'(FRAME_CYCLES - 1));

  assign w_an       = r_s1[15:8];
  assign w_one_low  = $onehot(~w_an);
  assign w_none_low = &w_an;

  always_comb begin
    w_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!w_an[k]) w_idx = 3'(k);
    end
  end

  // Active-low segment patterns, g..a
  always_comb begin
    w_hex    = 4'h0;
    w_hex_ok = 1'b1;
    case (r_s1[7:1])
      7'b1000000: w_hex = 4'h0;
      7'b1111001: w_hex = 4'h1;
      7'b0100100: w_hex = 4'h2;
      7'b0110000: w_hex = 4'h3;
      7'b0011001: w_hex = 4'h4;
      7'b0010010: w_hex = 4'h5;
      7'b0000010: w_hex = 4'h6;
      7'b1111000: w_hex = 4'h7;
      7'b0000000: w_hex = 4'h8;
      7'b0010000: w_hex = 4'h9;
      7'b0001000: w_hex = 4'hA;
      7'b0000011: w_hex = 4'hB;
      7'b1000110: w_hex = 4'hC;
      7'b0100001: w_hex = 4'hD;
      7'b0000110: w_hex = 4'hE;
      7'b0001110: w_hex = 4'hF;
      default:    w_hex_ok = 1'b0;
    endcase
  end

  assign w_write    = w_accept && w_one_low && w_hex_ok;
  assign w_wmask    = w_write ? (8'b1 << w_idx) : 8'h00;
  // A write on the terminal-count cycle still counts for the ending frame.
  assign w_seen_eff = r_seen | w_wmask;
  assign w_word     = {1'b1, w_hex, ~r_s1[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1         <= c_IDLE;
      r_s_prev     <= c_IDLE;
      r_cnt        <= '0;
      r_frm        <= '0;
      r_seen       <= 8'h00;
      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_anode_err  <= 1'b0;
      for (int k = 0; k < 8; k++) r_dig[k] <= 6'b000000;
    end else begin
      r_s1     <= {bus.AN, bus.sseg, bus.DP};
      r_s_prev <= r_s1;

      if (!w_equal)
        r_cnt <= '0;
      else if (r_cnt != c_CNT_W'(STABLE_CYCLES))
        r_cnt <= r_cnt + c_CNT_W'(1);

      r_frm        <= w_tc ? '0 : r_frm + c_FRM_W'(1);
      r_frame_done <= w_tc;
      r_seen       <= w_tc ? 8'h00 : w_seen_eff;

      for (int k = 0; k < 8; k++) begin
        if (w_tc && !w_seen_eff[k])
          r_dig[k] <= 6'b000000;
        else if (w_wmask[k])
          r_dig[k] <= w_word;
      end

      // A new error outranks a coincident clear.
      if (w_accept && w_one_low && !w_hex_ok)
        r_seg_err <= 1'b1;
      else if (bus.clr_err)
        r_seg_err <= 1'b0;

      if (w_accept && !w_one_low && !w_none_low)
        r_anode_err <= 1'b1;
      else if (bus.clr_err)
        r_anode_err <= 1'b0;
    end
  end

  assign bus.O0         = r_dig[0];
  assign bus.O1         = r_dig[1];
  assign bus.O2         = r_dig[2];
  assign bus.O3         = r_dig[3];
  assign bus.O4         = r_dig[4];
  assign bus.O5         = r_dig[5];
  assign bus.O6         = r_dig[6];
  assign bus.O7         = r_dig[7];
  assign bus.frame_done = r_frame_done;
  assign bus.seg_err    = r_seg_err;
  assign bus.anode_err  = r_anode_err;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_monitor
//  Purpose  : Self-checking bench for sseg_scan_monitor. Directed steps and a
//             randomized scan phase, every cycle compared with a run-length
//             reference model of the display bus.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sseg_scan_monitor;
  localparam int STABLE = 4;
  localparam int FRAME  = 200;
  localparam logic [15:0] IDLE = 16'hFFFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sseg_scan_monitor_if bus ();

  sseg_scan_monitor #(
    .STABLE_CYCLES(STABLE),
    .FRAME_CYCLES (FRAME)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0]  seg_tab [16];
  logic [5:0]  m_dig [8];
  logic [7:0]  m_seen;
  logic        m_fd, m_seg, m_an;
  logic [15:0] run_val;
  int          run_len;
  int          n_edge;

  function automatic int hex_of(logic [6:0] p);
    for (int h = 0; h < 16; h++) if (seg_tab[h] == p) return h;
    return -1;
  endfunction

  function automatic logic [50:0] observed();
    return {bus.O7, bus.O6, bus.O5, bus.O4, bus.O3, bus.O2, bus.O1, bus.O0,
            bus.frame_done, bus.seg_err, bus.anode_err};
  endfunction

  function automatic logic [50:0] expected();
    return {m_dig[7], m_dig[6], m_dig[5], m_dig[4], m_dig[3], m_dig[2],
            m_dig[1], m_dig[0], m_fd, m_seg, m_an};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 6'b000000;
    m_seen  = 8'h00;
    m_fd    = 1'b0;
    m_seg   = 1'b0;
    m_an    = 1'b0;
    run_val = IDLE;
    run_len = 2;   // reset preloads two idle samples
    n_edge  = 0;
  endtask

  // One clock edge of the reference: a run of equal samples is accepted
  // on the edge after its (STABLE+1)-th sample.
  task automatic model_edge();
    logic [15:0] x;
    logic [7:0]  an;
    int          h, k, zeros;
    bit          tc, seg_set, an_set;
    if (reset) begin
      model_reset();
      return;
    end
    x       = {bus.AN, bus.sseg, bus.DP};
    n_edge++;
    tc      = (n_edge % FRAME) == 0;
    seg_set = 1'b0;
    an_set  = 1'b0;
    if (run_len == STABLE + 1) begin
      an    = run_val[15:8];
      zeros = 8 - $countones(an);
      if (zeros == 1) begin
        k = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) k = i;
        h = hex_of(run_val[7:1]);
        if (h >= 0) begin
          m_dig[k]  = {1'b1, 4'(h), ~run_val[0]};
          m_seen[k] = 1'b1;
        end else begin
          seg_set = 1'b1;
        end
      end else if (zeros >= 2) begin
        an_set = 1'b1;
      end
    end
    if (tc) begin
      for (int i = 0; i < 8; i++) if (!m_seen[i]) m_dig[i] = 6'b000000;
      m_seen = 8'h00;
    end
    m_seg = seg_set | (m_seg & ~bus.clr_err);
    m_an  = an_set  | (m_an  & ~bus.clr_err);
    m_fd  = tc;
    if (x == run_val) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_val = x;
      run_len = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cycle", 64'(observed()), 64'(expected()));
  endtask

  task automatic set_in(logic [7:0] an, logic [6:0] sg, logic dp);
    bus.AN   = an;
    bus.sseg = sg;
    bus.DP   = dp;
  endtask

  task automatic drive_digit(int k, int hx, bit dp_on, int cycles);
    logic [7:0] an;
    an = ~(8'b1 << k);
    set_in(an, seg_tab[hx], ~dp_on);
    repeat (cycles) tick();
  endtask

  task automatic scan(logic [7:0] blank, logic [7:0] dpm, int slot);
    for (int k = 0; k < 8; k++) begin
      if (blank[k]) begin
        set_in(8'hFF, seg_tab[k], 1'b1);
        repeat (slot) tick();
      end else begin
        drive_digit(k, k, dpm[k], slot);
      end
    end
  endtask

  task automatic wait_fd(int limit, output int edges);
    edges = 0;
    forever begin
      tick();
      edges++;
      if (bus.frame_done) break;
      if (edges >= limit) begin
        total++;
        bad++;
        $error("FAIL fd_timeout edges=%0d limit=%0d", edges, limit);
        break;
      end
    end
  endtask

  // Called just after a falling edge; leaves reset released at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    set_in(8'hFF, 7'h7F, 1'b1);
    bus.clr_err = 1'b0;
    #1;
    check("reset_async", 64'(observed()), 64'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int          e;
    int          kind, len, k, hx;
    logic [7:0]  an;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    set_in(8'hFF, 7'h7F, 1'b1);
    bus.clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single stable digit 0 showing 3 with dp lit
    set_in(8'hFE, 7'b0110000, 1'b0);
    repeat (5) tick();
    check("t1_o0_early", 64'(bus.O0), 64'd0);
    tick();
    check("t1_o0", 64'(bus.O0), 64'(6'b100111));
    check("t1_others", 64'({bus.O7, bus.O6, bus.O5, bus.O4, bus.O3, bus.O2, bus.O1}), 64'd0);

    // Full scan of hex 0..7, dp only on digit 3
    do_reset();
    scan(8'h00, 8'h08, 20);
    wait_fd(FRAME + 10, e);
    check("t2_fd_edges", 64'(e), 64'(FRAME - 160));
    check("t2_o0", 64'(bus.O0), 64'(6'b100000));
    check("t2_o3", 64'(bus.O3), 64'(6'b100111));
    check("t2_o7", 64'(bus.O7), 64'(6'b101110));

    // Digit 5 blanked for the whole frame
    scan(8'h20, 8'h08, 20);
    wait_fd(FRAME + 10, e);
    check("t3_o5", 64'(bus.O5), 64'd0);
    check("t3_o4", 64'(bus.O4), 64'(6'b101000));
    check("t3_flags", 64'({bus.seg_err, bus.anode_err}), 64'd0);

    // Three-cycle glitch on digit 4 between valid slots
    drive_digit(3, 3, 1'b1, 20);
    set_in(8'hEF, 7'b0000000, 1'b1);
    repeat (3) tick();
    drive_digit(5, 5, 1'b0, 20);
    check("t4_o4", 64'(bus.O4), 64'(6'b101000));
    check("t4_flags", 64'({bus.seg_err, bus.anode_err}), 64'd0);

    // Anode and segment errors, then clear
    set_in(8'hFC, seg_tab[8], 1'b1);
    repeat (10) tick();
    check("t5_anode_err", 64'(bus.anode_err), 64'd1);
    check("t5_o0", 64'(bus.O0), 64'(6'b100000));
    check("t5_o1", 64'(bus.O1), 64'(6'b100010));
    set_in(8'hFB, 7'b1111111, 1'b1);
    repeat (10) tick();
    check("t5_seg_err", 64'(bus.seg_err), 64'd1);
    check("t5_o2", 64'(bus.O2), 64'(6'b100100));
    set_in(8'hFF, 7'h7F, 1'b1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("t5_clr", 64'({bus.seg_err, bus.anode_err}), 64'd0);

    // Clear coincident with a new anode error: the error wins
    set_in(8'hFC, seg_tab[1], 1'b1);
    repeat (5) tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("clr_vs_err", 64'(bus.anode_err), 64'd1);

    // Accept landing on the terminal-count edge
    do_reset();
    repeat (FRAME - 6) tick();
    set_in(8'hBF, seg_tab[9], 1'b1);
    repeat (6) tick();
    check("tc_fd", 64'(bus.frame_done), 64'd1);
    check("tc_o6", 64'(bus.O6), 64'(6'b110010));
    wait_fd(FRAME + 10, e);
    check("tc_next_edges", 64'(e), 64'(FRAME));
    check("tc_o6_blanked", 64'(bus.O6), 64'd0);

    // Randomized scanning against the model
    do_reset();
    for (int r = 0; r < 160; r++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 30);
      k    = $urandom_range(0, 7);
      hx   = $urandom_range(0, 15);
      an   = ~(8'b1 << k);
      case (kind)
        6:       set_in(8'hFF, seg_tab[hx], 1'(ir_bit()));
        7:       set_in(8'($urandom), seg_tab[hx], 1'(ir_bit()));
        8:       set_in(an, 7'($urandom), 1'(ir_bit()));
        default: set_in(an, seg_tab[hx], 1'(ir_bit()));
      endcase
      repeat (len) begin
        bus.clr_err = ($urandom_range(0, 19) == 0);
        tick();
      end
      bus.clr_err = 1'b0;
    end

    // Reset in the middle of a populated scan
    drive_digit(2, 12, 1'b1, 7);
    do_reset();
    wait_fd(FRAME + 10, e);
    check("t6_first_fd", 64'(e), 64'(FRAME));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int ir_bit();
    return int'($urandom_range(0, 1));
  endfunction

endmodule
`default_nettype wire
